// File: rtl/mem_bus_arbiter_pkg.sv
// Shared widths, memory access codes and arbiter state encoding for the
// memory-bus arbiter and its picker.
package mem_bus_arbiter_pkg;

    localparam int ADDR_W      = 32;
    localparam int WORD_W      = 32;
    localparam int MEM_COUNT_W = 3;
    localparam int MEM_CODE_W  = 3;

    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 3'd0;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 3'd1;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 3'd2;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 3'd4;

    localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID       = 3'd0;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ          = 3'd1;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE         = 3'd2;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED    = 3'd3;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_OUT_OF_BOUNDS = 3'd4;

    typedef enum logic [1:0] {
        ARB_ST_IDLE  = 2'd0,
        ARB_ST_ISSUE = 2'd1,
        ARB_ST_WAIT  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]      addr;
        logic [WORD_W-1:0]      wr_data;
        logic                   wr_en;
        logic [MEM_COUNT_W-1:0] count;
    } mem_req_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational two-way picker: fixed priority to port 0, or alternation
// against the last winner when both ports request.
module mem_arb_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_winner,
    input  logic fixed_priority,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = 1'b0;
        if (req0 && req1) begin
            grant_id = fixed_priority ? 1'b0 : ~last_winner;
        end else if (req1) begin
            grant_id = 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one peripheral request port between load/store (port 0) and fetch
// (port 1); one transaction in flight, request-to-response latency 3 cycles.
//
// state | meaning
// IDLE  | waiting for a request; grant latches the winner's fields
// ISSUE | latched request driven downstream for this one cycle
// WAIT  | peripheral response captured and returned to the winner
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned FIXED_PRIORITY = 0
) (
    input  logic                   clk,
    input  logic                   aresetn,

    input  logic [ADDR_W-1:0]      i_p0_req_addr,
    input  logic [WORD_W-1:0]      i_p0_req_wr_data,
    input  logic                   i_p0_req_wr_en,
    input  logic [MEM_COUNT_W-1:0] i_p0_req_count,
    output logic                   o_p0_accept,
    output logic                   o_p0_res_valid,
    output logic [WORD_W-1:0]      o_p0_res_rd_data,
    output logic [MEM_CODE_W-1:0]  o_p0_res_code,

    input  logic [ADDR_W-1:0]      i_p1_req_addr,
    input  logic [WORD_W-1:0]      i_p1_req_wr_data,
    input  logic                   i_p1_req_wr_en,
    input  logic [MEM_COUNT_W-1:0] i_p1_req_count,
    output logic                   o_p1_accept,
    output logic                   o_p1_res_valid,
    output logic [WORD_W-1:0]      o_p1_res_rd_data,
    output logic [MEM_CODE_W-1:0]  o_p1_res_code,

    output logic [ADDR_W-1:0]      o_mem_req_addr,
    output logic [WORD_W-1:0]      o_mem_req_wr_data,
    output logic                   o_mem_req_wr_en,
    output logic [MEM_COUNT_W-1:0] o_mem_req_count,
    input  logic [WORD_W-1:0]      i_mem_res_rd_data,
    input  logic [MEM_CODE_W-1:0]  i_mem_res_code,

    output logic                   o_busy
);

    arb_state_t state;
    logic       winner;
    logic       grant_valid;
    logic       grant_id;
    mem_req_t   p0_req;
    mem_req_t   p1_req;
    mem_req_t   sel_req;

    assign p0_req = '{addr: i_p0_req_addr, wr_data: i_p0_req_wr_data,
                      wr_en: i_p0_req_wr_en, count: i_p0_req_count};
    assign p1_req = '{addr: i_p1_req_addr, wr_data: i_p1_req_wr_data,
                      wr_en: i_p1_req_wr_en, count: i_p1_req_count};
    assign sel_req = grant_id ? p1_req : p0_req;

    // The latched winner doubles as the round-robin history; it only moves on a grant.
    mem_arb_rr_pick u_pick (
        .req0          (i_p0_req_count != MEM_COUNT_NONE),
        .req1          (i_p1_req_count != MEM_COUNT_NONE),
        .last_winner   (winner),
        .fixed_priority(FIXED_PRIORITY != 0),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id)
    );

    assign o_busy = (state != ARB_ST_IDLE);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state             <= ARB_ST_IDLE;
            winner            <= 1'b1;
            o_mem_req_addr    <= '0;
            o_mem_req_wr_data <= '0;
            o_mem_req_wr_en   <= 1'b0;
            o_mem_req_count   <= MEM_COUNT_NONE;
            o_p0_accept       <= 1'b0;
            o_p1_accept       <= 1'b0;
            o_p0_res_valid    <= 1'b0;
            o_p1_res_valid    <= 1'b0;
            o_p0_res_rd_data  <= '0;
            o_p1_res_rd_data  <= '0;
            o_p0_res_code     <= MEM_CODE_INVALID;
            o_p1_res_code     <= MEM_CODE_INVALID;
        end else begin
            o_p0_accept    <= 1'b0;
            o_p1_accept    <= 1'b0;
            o_p0_res_valid <= 1'b0;
            o_p1_res_valid <= 1'b0;
            unique case (state)
                ARB_ST_IDLE: begin
                    if (grant_valid) begin
                        winner            <= grant_id;
                        o_mem_req_addr    <= sel_req.addr;
                        o_mem_req_wr_data <= sel_req.wr_data;
                        o_mem_req_wr_en   <= sel_req.wr_en;
                        o_mem_req_count   <= sel_req.count;
                        o_p0_accept       <= ~grant_id;
                        o_p1_accept       <= grant_id;
                        state             <= ARB_ST_ISSUE;
                    end
                end
                ARB_ST_ISSUE: begin
                    o_mem_req_count <= MEM_COUNT_NONE;
                    state           <= ARB_ST_WAIT;
                end
                ARB_ST_WAIT: begin
                    if (winner) begin
                        o_p1_res_rd_data <= i_mem_res_rd_data;
                        o_p1_res_code    <= i_mem_res_code;
                        o_p1_res_valid   <= 1'b1;
                    end else begin
                        o_p0_res_rd_data <= i_mem_res_rd_data;
                        o_p0_res_code    <= i_mem_res_code;
                        o_p0_res_valid   <= 1'b1;
                    end
                    state <= ARB_ST_IDLE;
                end
                default: state <= ARB_ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a transaction-level model predicts
// grants, cycles and peripheral responses; a negedge monitor checks the DUT.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int unsigned FP = 0;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] p0_addr, p0_wd, p1_addr, p1_wd;
    logic        p0_we, p1_we;
    logic [2:0]  p0_cnt, p1_cnt;
    logic        p0_acc, p1_acc, p0_rv, p1_rv;
    logic [31:0] p0_rd, p1_rd;
    logic [2:0]  p0_code, p1_code;
    logic [31:0] m_addr, m_wd;
    logic        m_we;
    logic [2:0]  m_cnt;
    logic [31:0] m_rd = '0;
    logic [2:0]  m_code = MEM_CODE_INVALID;
    logic        busy;

    mem_bus_arbiter #(.FIXED_PRIORITY(FP)) dut (
        .clk(clk), .aresetn(aresetn),
        .i_p0_req_addr(p0_addr), .i_p0_req_wr_data(p0_wd), .i_p0_req_wr_en(p0_we),
        .i_p0_req_count(p0_cnt), .o_p0_accept(p0_acc), .o_p0_res_valid(p0_rv),
        .o_p0_res_rd_data(p0_rd), .o_p0_res_code(p0_code),
        .i_p1_req_addr(p1_addr), .i_p1_req_wr_data(p1_wd), .i_p1_req_wr_en(p1_we),
        .i_p1_req_count(p1_cnt), .o_p1_accept(p1_acc), .o_p1_res_valid(p1_rv),
        .o_p1_res_rd_data(p1_rd), .o_p1_res_code(p1_code),
        .o_mem_req_addr(m_addr), .o_mem_req_wr_data(m_wd), .o_mem_req_wr_en(m_we),
        .o_mem_req_count(m_cnt), .i_mem_res_rd_data(m_rd), .i_mem_res_code(m_code),
        .o_busy(busy)
    );

    // Picker exercised on its own for the fixed-priority rule as well.
    logic pk_r0, pk_r1, pk_lw, pk_fp, pk_gv, pk_gid;
    mem_arb_rr_pick u_pk (.req0(pk_r0), .req1(pk_r1), .last_winner(pk_lw),
                          .fixed_priority(pk_fp), .grant_valid(pk_gv), .grant_id(pk_gid));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Peripheral behaviour: 16-byte window at address 0, little-endian lanes.
    typedef struct packed { logic [2:0] code; logic [31:0] rd; logic [31:0] nw; } acc_r_t;

    function automatic acc_r_t calc(input logic [31:0] addr, input logic [2:0] cnt,
                                    input logic we, input logic [31:0] wd, input logic [31:0] word);
        acc_r_t r;
        logic [32:0] n;
        logic [32:0] a;
        logic [31:0] mask;
        int off;
        r.code = MEM_CODE_INVALID;
        r.rd   = '0;
        r.nw   = word;
        n = {30'd0, cnt};
        a = {1'b0, addr};
        if (cnt != 3'd1 && cnt != 3'd2 && cnt != 3'd4) return r;
        if ((a % n) != 33'd0) begin
            r.code = MEM_CODE_MISALIGNED;
            return r;
        end
        if (a + n > 33'd16) begin
            r.code = MEM_CODE_OUT_OF_BOUNDS;
            return r;
        end
        off  = 8 * int'(addr[1:0]);
        mask = (cnt == 3'd4) ? 32'hFFFF_FFFF : ((cnt == 3'd2) ? 32'h0000_FFFF : 32'h0000_00FF);
        if (we) begin
            r.code = MEM_CODE_WRITE;
            r.nw   = (word & ~(mask << off)) | ((wd & mask) << off);
        end else begin
            r.code = MEM_CODE_READ;
            r.rd   = (word >> off) & mask;
        end
        return r;
    endfunction

    logic [31:0] dev_mem [4] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
    always @(posedge clk) begin
        acc_r_t r;
        if (m_cnt != MEM_COUNT_NONE) begin
            r = calc(m_addr, m_cnt, m_we, m_wd, dev_mem[m_addr[3:2]]);
            m_rd   <= r.rd;
            m_code <= r.code;
            if (r.code == MEM_CODE_WRITE) dev_mem[m_addr[3:2]] <= r.nw;
        end else begin
            m_rd   <= '0;
            m_code <= MEM_CODE_INVALID;
        end
    end

    // ---------------- transaction model and scoreboard queues ----------------
    typedef struct {
        int port; int cyc;
        logic [31:0] addr; logic [31:0] wd; logic we; logic [2:0] cnt;
    } acc_exp_t;
    typedef struct { int port; int cyc; logic [31:0] rd; logic [2:0] code; } res_exp_t;

    acc_exp_t acc_q[$];
    res_exp_t res_q[$];

    logic [31:0] ref_mem [4] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
    int free_cyc = 0;
    int last_w = 1;
    bit          act [2];
    logic [31:0] r_addr [2];
    logic [31:0] r_wd [2];
    logic        r_we [2];
    logic [2:0]  r_cnt [2];
    int          done_at [2] = '{-1, -1};
    int          mode [2] = '{0, 0};   // 0 single shot, 1 repeat same request, 2 random

    task automatic apply_inputs();
        p0_addr = act[0] ? r_addr[0] : '0;
        p0_wd   = act[0] ? r_wd[0]   : '0;
        p0_we   = act[0] ? r_we[0]   : 1'b0;
        p0_cnt  = act[0] ? r_cnt[0]  : MEM_COUNT_NONE;
        p1_addr = act[1] ? r_addr[1] : '0;
        p1_wd   = act[1] ? r_wd[1]   : '0;
        p1_we   = act[1] ? r_we[1]   : 1'b0;
        p1_cnt  = act[1] ? r_cnt[1]  : MEM_COUNT_NONE;
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic we,
                           input logic [31:0] wd, input logic [2:0] c);
        act[p] = 1'b1; r_addr[p] = a; r_we[p] = we; r_wd[p] = wd; r_cnt[p] = c;
        apply_inputs();
    endtask

    task automatic rand_req(input int p);
        logic [2:0] c;
        case ($urandom_range(0, 7))
            0, 1, 2: c = MEM_COUNT_WORD;
            3, 4:    c = MEM_COUNT_HALF;
            5, 6:    c = MEM_COUNT_BYTE;
            default: c = 3'd3;
        endcase
        act[p] = 1'b1;
        r_addr[p] = 32'($urandom_range(0, 23));
        r_we[p] = 1'($urandom_range(0, 1));
        r_wd[p] = $urandom;
        r_cnt[p] = c;
    endtask

    // One grant every third cycle at most; both pending -> the port that did not win last.
    task automatic grant_eval();
        int w;
        acc_r_t r;
        acc_exp_t ae;
        res_exp_t re;
        if (!act[0] && !act[1]) return;
        if (act[0] && act[1]) w = (FP != 0) ? 0 : 1 - last_w;
        else w = act[1] ? 1 : 0;
        last_w = w;
        free_cyc = cyc + 3;
        r = calc(r_addr[w], r_cnt[w], r_we[w], r_wd[w], ref_mem[r_addr[w][3:2]]);
        if (r.code == MEM_CODE_WRITE) ref_mem[r_addr[w][3:2]] = r.nw;
        ae.port = w; ae.cyc = cyc + 1; ae.addr = r_addr[w]; ae.wd = r_wd[w];
        ae.we = r_we[w]; ae.cnt = r_cnt[w];
        acc_q.push_back(ae);
        re.port = w; re.cyc = cyc + 3; re.rd = r.rd; re.code = r.code;
        res_q.push_back(re);
        done_at[w] = cyc + 2;
    endtask

    task automatic step();
        if (aresetn && cyc >= free_cyc) grant_eval();
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (act[p] && done_at[p] == cyc) begin
                act[p] = 1'b0;
                if (mode[p] == 1) act[p] = 1'b1;
                else if (mode[p] == 2 && $urandom_range(0, 1) == 1) rand_req(p);
            end else if (!act[p] && mode[p] == 2 && $urandom_range(0, 2) == 0) begin
                rand_req(p);
            end
        end
        apply_inputs();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((act[0] || act[1] || acc_q.size() != 0 || res_q.size() != 0) && n < 300) begin
            step();
            n++;
        end
        chk("drain_timeout", 64'(n >= 300), 64'd0);
    endtask

    // ---------------- monitor ----------------
    logic [31:0] ml_rd [2];
    logic [2:0]  ml_code [2];

    always @(negedge clk) begin
        acc_exp_t ae;
        res_exp_t re;
        if (!aresetn) begin
            ml_rd[0] = '0; ml_rd[1] = '0;
            ml_code[0] = MEM_CODE_INVALID; ml_code[1] = MEM_CODE_INVALID;
        end else begin
            if (acc_q.size() != 0 && acc_q[0].cyc == cyc) begin
                ae = acc_q.pop_front();
                chk("accept_port", {62'd0, p1_acc, p0_acc}, (ae.port == 1) ? 64'd2 : 64'd1);
                chk("mem_req_addr", 64'(m_addr), 64'(ae.addr));
                chk("mem_req_wr_data", 64'(m_wd), 64'(ae.wd));
                chk("mem_req_wr_en", 64'(m_we), 64'(ae.we));
                chk("mem_req_count", 64'(m_cnt), 64'(ae.cnt));
                chk("busy_in_issue", 64'(busy), 64'd1);
            end else if (p0_acc || p1_acc) begin
                chk("unexpected_accept", {62'd0, p1_acc, p0_acc}, 64'd0);
            end
            if (res_q.size() != 0 && res_q[0].cyc == cyc) begin
                re = res_q.pop_front();
                ml_rd[re.port] = re.rd;
                ml_code[re.port] = re.code;
                chk("res_valid_port", {62'd0, p1_rv, p0_rv}, (re.port == 1) ? 64'd2 : 64'd1);
                chk("p0_res_rd_data", 64'(p0_rd), 64'(ml_rd[0]));
                chk("p0_res_code", 64'(p0_code), 64'(ml_code[0]));
                chk("p1_res_rd_data", 64'(p1_rd), 64'(ml_rd[1]));
                chk("p1_res_code", 64'(p1_code), 64'(ml_code[1]));
                chk("mem_req_idle", 64'(m_cnt), 64'(MEM_COUNT_NONE));
                chk("busy_after_res", 64'(busy), 64'd0);
            end else if (p0_rv || p1_rv) begin
                chk("unexpected_res_valid", {62'd0, p1_rv, p0_rv}, 64'd0);
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_accept"}, {62'd0, p1_acc, p0_acc}, 64'd0);
        chk({tag, "_res_valid"}, {62'd0, p1_rv, p0_rv}, 64'd0);
        chk({tag, "_rd_data"}, {p1_rd, p0_rd}, 64'd0);
        chk({tag, "_p0_code"}, 64'(p0_code), 64'(MEM_CODE_INVALID));
        chk({tag, "_p1_code"}, 64'(p1_code), 64'(MEM_CODE_INVALID));
        chk({tag, "_mem_addr_wd"}, {m_addr, m_wd}, 64'd0);
        chk({tag, "_mem_we"}, 64'(m_we), 64'd0);
        chk({tag, "_mem_count"}, 64'(m_cnt), 64'(MEM_COUNT_NONE));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        act = '{1'b0, 1'b0};
        apply_inputs();
        pk_r0 = 0; pk_r1 = 0; pk_lw = 0; pk_fp = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");

        for (int k = 0; k < 16; k++) begin
            logic [3:0] v;
            logic exp_id;
            v = 4'(k);
            {pk_fp, pk_lw, pk_r1, pk_r0} = v;
            #1;
            if (v[0] && v[1]) exp_id = v[3] ? 1'b0 : ~v[2];
            else exp_id = v[1];
            chk("pick_valid", 64'(pk_gv), 64'(v[0] | v[1]));
            if (v[0] | v[1]) chk("pick_id", 64'(pk_gid), 64'(exp_id));
        end

        aresetn = 1'b1;
        @(posedge clk);
        #1;

        // Conflict straight after reset: port 0 first, then strict alternation.
        mode = '{1, 1};
        set_req(0, 32'h4, 1'b0, 32'h0, MEM_COUNT_WORD);
        set_req(1, 32'h8, 1'b0, 32'h0, MEM_COUNT_WORD);
        repeat (24) step();
        mode = '{0, 0};
        wait_idle();

        set_req(0, 32'h4, 1'b0, 32'h0, MEM_COUNT_WORD);
        wait_idle();
        chk("single_read_data", 64'(p0_rd), 64'hDEADBEEF);
        chk("single_read_code", 64'(p0_code), 64'(MEM_CODE_READ));

        set_req(1, 32'h1, 1'b1, 32'h1234, MEM_COUNT_HALF);
        wait_idle();
        chk("misaligned_code", 64'(p1_code), 64'(MEM_CODE_MISALIGNED));
        chk("misaligned_data", 64'(p1_rd), 64'd0);
        set_req(0, 32'h20, 1'b0, 32'h0, MEM_COUNT_WORD);
        wait_idle();
        chk("oob_code", 64'(p0_code), 64'(MEM_CODE_OUT_OF_BOUNDS));
        chk("oob_data", 64'(p0_rd), 64'd0);

        set_req(0, 32'h2, 1'b1, 32'hAB, MEM_COUNT_BYTE);
        wait_idle();
        set_req(1, 32'h0, 1'b0, 32'h0, MEM_COUNT_WORD);
        wait_idle();
        chk("wr_rd_data", 64'(p1_rd), 64'h00AB0000);
        chk("wr_rd_code", 64'(p1_code), 64'(MEM_CODE_READ));

        mode = '{2, 2};
        repeat (900) step();
        mode = '{0, 0};
        wait_idle();

        // Reset during WAIT: drop the port 0 transaction, keep port 1 pending.
        set_req(0, 32'h4, 1'b0, 32'h0, MEM_COUNT_WORD);
        step();
        set_req(1, 32'h8, 1'b0, 32'h0, MEM_COUNT_WORD);
        step();
        chk("busy_before_reset", 64'(busy), 64'd1);
        aresetn = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        acc_q.delete();
        res_q.delete();
        free_cyc = 0;
        last_w = 1;
        act[0] = 1'b0;
        apply_inputs();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        aresetn = 1'b1;
        wait_idle();
        chk("post_reset_p0_code", 64'(p0_code), 64'(MEM_CODE_INVALID));
        chk("post_reset_p1_code", 64'(p1_code), 64'(MEM_CODE_READ));
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
